// File: rtl/color_target_calibrator.sv
// Calibration controller for the two-color U/V mask: averages chroma over a centred window
// and commits targets and shadowed thresholds only on frame boundaries.
module color_target_calibrator #(
  parameter int unsigned YUV_WIDTH    = 8,
  parameter int unsigned THRESH_WIDTH = 8,
  parameter int unsigned X_WIDTH      = 10,
  parameter int unsigned Y_WIDTH      = 10,
  parameter int unsigned WIN_X0       = 312,
  parameter int unsigned WIN_Y0       = 232,
  parameter int unsigned WIN_LOG2     = 4,
  parameter int          U1_DEF       = 0,
  parameter int          V1_DEF       = 0,
  parameter int          U2_DEF       = 0,
  parameter int          V2_DEF       = 0,
  parameter int          THRESH_DEF   = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic                           pix_valid,
  input  logic        [X_WIDTH-1:0]      pix_x,
  input  logic        [Y_WIDTH-1:0]      pix_y,
  input  logic signed [YUV_WIDTH-1:0]    U,
  input  logic signed [YUV_WIDTH-1:0]    V,
  input  logic                           cal_req,
  input  logic                           cal_sel,
  input  logic signed [THRESH_WIDTH-1:0] uThresh_in1,
  input  logic signed [THRESH_WIDTH-1:0] vThresh_in1,
  input  logic signed [THRESH_WIDTH-1:0] uThresh_in2,
  input  logic signed [THRESH_WIDTH-1:0] vThresh_in2,
  output logic signed [YUV_WIDTH-1:0]    uTarget1,
  output logic signed [YUV_WIDTH-1:0]    vTarget1,
  output logic signed [YUV_WIDTH-1:0]    uTarget2,
  output logic signed [YUV_WIDTH-1:0]    vTarget2,
  output logic signed [THRESH_WIDTH-1:0] uThresh1,
  output logic signed [THRESH_WIDTH-1:0] vThresh1,
  output logic signed [THRESH_WIDTH-1:0] uThresh2,
  output logic signed [THRESH_WIDTH-1:0] vThresh2,
  output logic                           busy,
  output logic                           cal_done,
  output logic                           cal_err
);

  localparam int unsigned ExtW = 2 * WIN_LOG2;
  localparam int unsigned SumW = YUV_WIDTH + ExtW;
  localparam int unsigned CntW = ExtW + 1;
  localparam logic [CntW-1:0]  Npix  = {1'b1, {ExtW{1'b0}}};
  localparam logic [X_WIDTH:0] WinX0 = (X_WIDTH+1)'(WIN_X0);
  localparam logic [X_WIDTH:0] WinX1 = (X_WIDTH+1)'(WIN_X0 + (1 << WIN_LOG2));
  localparam logic [Y_WIDTH:0] WinY0 = (Y_WIDTH+1)'(WIN_Y0);
  localparam logic [Y_WIDTH:0] WinY1 = (Y_WIDTH+1)'(WIN_Y0 + (1 << WIN_LOG2));

  typedef enum logic [2:0] {StIdle, StArm, StAccum, StCompute, StCommit} state_e;

  state_e                         state_q, state_d;
  logic                           sel_q, sel_d;
  logic signed [SumW-1:0]         u_sum_q, u_sum_d, v_sum_q, v_sum_d;
  logic        [CntW-1:0]         cnt_q, cnt_d;
  logic signed [YUV_WIDTH-1:0]    u_avg_q, u_avg_d, v_avg_q, v_avg_d;
  logic signed [YUV_WIDTH-1:0]    ut1_q, ut1_d, vt1_q, vt1_d, ut2_q, ut2_d, vt2_q, vt2_d;
  logic signed [THRESH_WIDTH-1:0] uth1_q, uth1_d, vth1_q, vth1_d, uth2_q, uth2_d, vth2_q, vth2_d;
  logic                           busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic                           in_win;
  logic signed [SumW-1:0]         u_ext, v_ext;
  logic        [CntW-1:0]         cnt_inc;

  assign in_win = pix_valid &&
                  ({1'b0, pix_x} >= WinX0) && ({1'b0, pix_x} < WinX1) &&
                  ({1'b0, pix_y} >= WinY0) && ({1'b0, pix_y} < WinY1);
  assign u_ext   = {{ExtW{U[YUV_WIDTH-1]}}, U};
  assign v_ext   = {{ExtW{V[YUV_WIDTH-1]}}, V};
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    u_sum_d = u_sum_q;
    v_sum_d = v_sum_q;
    cnt_d   = cnt_q;
    u_avg_d = u_avg_q;
    v_avg_d = v_avg_q;
    ut1_d   = ut1_q;
    vt1_d   = vt1_q;
    ut2_d   = ut2_q;
    vt2_d   = vt2_q;
    uth1_d  = uth1_q;
    vth1_d  = vth1_q;
    uth2_d  = uth2_q;
    vth2_d  = vth2_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    // Thresholds follow their inputs only at frame boundaries, whatever the FSM is doing.
    if (frame_start) begin
      uth1_d = uThresh_in1;
      vth1_d = vThresh_in1;
      uth2_d = uThresh_in2;
      vth2_d = vThresh_in2;
    end

    unique case (state_q)
      StIdle: begin
        if (cal_req) begin
          state_d = StArm;
          sel_d   = cal_sel;
          u_sum_d = '0;
          v_sum_d = '0;
          cnt_d   = '0;
        end
      end
      StArm: begin
        if (frame_start) state_d = StAccum;
      end
      StAccum: begin
        if (frame_start) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (in_win) begin
          u_sum_d = u_sum_q + u_ext;
          v_sum_d = v_sum_q + v_ext;
          cnt_d   = cnt_inc;
          if (cnt_inc == Npix) state_d = StCompute;
        end
      end
      StCompute: begin
        // Arithmetic shift floors toward minus infinity.
        u_avg_d = YUV_WIDTH'(u_sum_q >>> ExtW);
        v_avg_d = YUV_WIDTH'(v_sum_q >>> ExtW);
        state_d = StCommit;
      end
      StCommit: begin
        if (frame_start) begin
          if (sel_q) begin
            ut2_d = u_avg_q;
            vt2_d = v_avg_q;
          end else begin
            ut1_d = u_avg_q;
            vt1_d = v_avg_q;
          end
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sel_q   <= 1'b0;
      u_sum_q <= '0;
      v_sum_q <= '0;
      cnt_q   <= '0;
      u_avg_q <= '0;
      v_avg_q <= '0;
      ut1_q   <= YUV_WIDTH'(U1_DEF);
      vt1_q   <= YUV_WIDTH'(V1_DEF);
      ut2_q   <= YUV_WIDTH'(U2_DEF);
      vt2_q   <= YUV_WIDTH'(V2_DEF);
      uth1_q  <= THRESH_WIDTH'(THRESH_DEF);
      vth1_q  <= THRESH_WIDTH'(THRESH_DEF);
      uth2_q  <= THRESH_WIDTH'(THRESH_DEF);
      vth2_q  <= THRESH_WIDTH'(THRESH_DEF);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      u_sum_q <= u_sum_d;
      v_sum_q <= v_sum_d;
      cnt_q   <= cnt_d;
      u_avg_q <= u_avg_d;
      v_avg_q <= v_avg_d;
      ut1_q   <= ut1_d;
      vt1_q   <= vt1_d;
      ut2_q   <= ut2_d;
      vt2_q   <= vt2_d;
      uth1_q  <= uth1_d;
      vth1_q  <= vth1_d;
      uth2_q  <= uth2_d;
      vth2_q  <= vth2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign uTarget1 = ut1_q;
  assign vTarget1 = vt1_q;
  assign uTarget2 = ut2_q;
  assign vTarget2 = vt2_q;
  assign uThresh1 = uth1_q;
  assign vThresh1 = vth1_q;
  assign uThresh2 = uth2_q;
  assign vThresh2 = vth2_q;
  assign busy     = busy_q;
  assign cal_done = done_q;
  assign cal_err  = err_q;

endmodule

// File: tb/tb_color_target_calibrator.sv
// Directed bench for color_target_calibrator: window averaging, rounding, abort, lockout,
// mid-run reset and threshold shadowing, each with hand-computed expectations.
module tb_color_target_calibrator;

  logic              clk = 1'b0;
  logic              reset_n, frame_start, pix_valid, cal_req, cal_sel;
  logic        [9:0] pix_x, pix_y;
  logic signed [7:0] U, V;
  logic signed [7:0] uThresh_in1, vThresh_in1, uThresh_in2, vThresh_in2;
  logic signed [7:0] uTarget1, vTarget1, uTarget2, vTarget2;
  logic signed [7:0] uThresh1, vThresh1, uThresh2, vThresh2;
  logic              busy, cal_done, cal_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  color_target_calibrator dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .U           (U),
    .V           (V),
    .cal_req     (cal_req),
    .cal_sel     (cal_sel),
    .uThresh_in1 (uThresh_in1),
    .vThresh_in1 (vThresh_in1),
    .uThresh_in2 (uThresh_in2),
    .vThresh_in2 (vThresh_in2),
    .uTarget1    (uTarget1),
    .vTarget1    (vTarget1),
    .uTarget2    (uTarget2),
    .vTarget2    (vTarget2),
    .uThresh1    (uThresh1),
    .vThresh1    (vThresh1),
    .uThresh2    (uThresh2),
    .vThresh2    (vThresh2),
    .busy        (busy),
    .cal_done    (cal_done),
    .cal_err     (cal_err)
  );

  // Inputs set before cyc() are seen at its edge; outputs are read 1ns after that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic request(input logic sel);
    cal_req = 1'b1;
    cal_sel = sel;
    cyc();
    cal_req = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int u, input int v);
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    U         = 8'(u);
    V         = 8'(v);
    cyc();
    pix_valid = 1'b0;
  endtask

  // Window pixels start..start+n-1 in raster order; the first 128 get u_a, the rest u_b.
  task automatic send_win(input int start, input int n, input int u_a, input int u_b,
                          input int v);
    for (int i = start; i < start + n; i++)
      pix(312 + (i % 16), 232 + (i / 16), (i < 128) ? u_a : u_b, v);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    checks++; if (uTarget1 !== 8'sd0) $display("FAIL reset_uTarget1 got %0d want 0", uTarget1); else passed++;
    checks++; if (vTarget2 !== 8'sd0) $display("FAIL reset_vTarget2 got %0d want 0", vTarget2); else passed++;
    checks++; if (uThresh1 !== 8'sd8) $display("FAIL reset_uThresh1 got %0d want 8", uThresh1); else passed++;
    checks++; if (vThresh2 !== 8'sd8) $display("FAIL reset_vThresh2 got %0d want 8", vThresh2); else passed++;
    checks++; if ({busy, cal_done, cal_err} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {busy, cal_done, cal_err}); else passed++;
  endtask

  task automatic test_uniform();
    request(1'b0);
    checks++; if (busy !== 1'b1) $display("FAIL uni_busy_after_req got %b want 1", busy); else passed++;
    pulse_fs();
    pix(0, 0, 100, 100);
    pix(328, 232, 100, 100);
    pix(311, 240, 100, 100);
    pix(320, 248, 100, 100);
    pix(320, 231, 100, 100);
    send_win(0, 256, 20, 20, -30);
    cyc();
    checks++; if (cal_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL uni_wait_commit got done=%b busy=%b want 0 1", cal_done, busy); else passed++;
    pulse_fs();
    checks++; if (cal_done !== 1'b1) $display("FAIL uni_done got %b want 1", cal_done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL uni_busy_clear got %b want 0", busy); else passed++;
    checks++; if (uTarget1 !== 8'sd20) $display("FAIL uni_uTarget1 got %0d want 20", uTarget1); else passed++;
    checks++; if (vTarget1 !== -8'sd30) $display("FAIL uni_vTarget1 got %0d want -30", vTarget1); else passed++;
    checks++; if (uTarget2 !== 8'sd0 || vTarget2 !== 8'sd0)
      $display("FAIL uni_t2_untouched got %0d %0d want 0 0", uTarget2, vTarget2); else passed++;
    cyc();
    checks++; if (cal_done !== 1'b0) $display("FAIL uni_done_one_cycle got %b want 0", cal_done); else passed++;
  endtask

  task automatic test_rounding();
    request(1'b1);
    pulse_fs();
    send_win(0, 256, 10, -11, 127);
    // A frame_start in the COMPUTE cycle must not commit.
    pulse_fs();
    checks++; if (cal_done !== 1'b0 || busy !== 1'b1)
      $display("FAIL rnd_no_commit_in_compute got done=%b busy=%b want 0 1", cal_done, busy);
    else passed++;
    cyc();
    pulse_fs();
    checks++; if (cal_done !== 1'b1) $display("FAIL rnd_done got %b want 1", cal_done); else passed++;
    checks++; if (uTarget2 !== -8'sd1) $display("FAIL rnd_uTarget2 got %0d want -1", uTarget2); else passed++;
    checks++; if (vTarget2 !== 8'sd127) $display("FAIL rnd_vTarget2 got %0d want 127", vTarget2); else passed++;
    checks++; if (uTarget1 !== 8'sd20 || vTarget1 !== -8'sd30)
      $display("FAIL rnd_t1_untouched got %0d %0d want 20 -30", uTarget1, vTarget1); else passed++;
  endtask

  task automatic test_abort();
    request(1'b0);
    pulse_fs();
    send_win(0, 100, 50, 50, 50);
    pulse_fs();
    checks++; if (cal_err !== 1'b1) $display("FAIL abort_err got %b want 1", cal_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    checks++; if (cal_done !== 1'b0) $display("FAIL abort_done got %b want 0", cal_done); else passed++;
    checks++; if (uTarget1 !== 8'sd20 || vTarget1 !== -8'sd30)
      $display("FAIL abort_targets got %0d %0d want 20 -30", uTarget1, vTarget1); else passed++;
    cyc();
    checks++; if (cal_err !== 1'b0) $display("FAIL abort_err_one_cycle got %b want 0", cal_err); else passed++;
  endtask

  task automatic test_lockout();
    int dones = 0;
    request(1'b0);
    pulse_fs();
    send_win(0, 50, -5, -5, 7);
    request(1'b1);
    send_win(50, 206, -5, -5, 7);
    cyc();
    frame_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      frame_start = 1'b0;
      if (cal_done === 1'b1) dones++;
    end
    checks++; if (dones !== 1) $display("FAIL lock_done_count got %0d want 1", dones); else passed++;
    checks++; if (uTarget1 !== -8'sd5 || vTarget1 !== 8'sd7)
      $display("FAIL lock_t1 got %0d %0d want -5 7", uTarget1, vTarget1); else passed++;
    checks++; if (uTarget2 !== -8'sd1 || vTarget2 !== 8'sd127)
      $display("FAIL lock_t2_untouched got %0d %0d want -1 127", uTarget2, vTarget2); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL lock_not_rearmed got %b want 0", busy); else passed++;
  endtask

  task automatic test_thresh();
    cyc();
    uThresh_in1 = 8'sd15;
    vThresh_in2 = -8'sd20;
    cyc();
    cyc();
    checks++; if (uThresh1 !== 8'sd8) $display("FAIL thr_hold got %0d want 8", uThresh1); else passed++;
    pulse_fs();
    checks++; if (uThresh1 !== 8'sd15) $display("FAIL thr_uThresh1 got %0d want 15", uThresh1); else passed++;
    checks++; if (vThresh2 !== -8'sd20) $display("FAIL thr_vThresh2 got %0d want -20", vThresh2); else passed++;
    checks++; if (vThresh1 !== 8'sd8) $display("FAIL thr_vThresh1 got %0d want 8", vThresh1); else passed++;
  endtask

  task automatic test_reset_mid();
    request(1'b0);
    pulse_fs();
    send_win(0, 60, 40, 40, 40);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    checks++; if (uTarget1 !== 8'sd0 || vTarget1 !== 8'sd0 || uTarget2 !== 8'sd0)
      $display("FAIL rstm_targets got %0d %0d %0d want 0 0 0", uTarget1, vTarget1, uTarget2);
    else passed++;
    checks++; if (uThresh1 !== 8'sd8 || vThresh2 !== 8'sd8)
      $display("FAIL rstm_thresh got %0d %0d want 8 8", uThresh1, vThresh2); else passed++;
    checks++; if ({busy, cal_done, cal_err} !== 3'b000)
      $display("FAIL rstm_flags got %b want 000", {busy, cal_done, cal_err}); else passed++;
    request(1'b1);
    pulse_fs();
    send_win(0, 256, 3, 3, -4);
    cyc();
    pulse_fs();
    checks++; if (cal_done !== 1'b1) $display("FAIL rstm_done got %b want 1", cal_done); else passed++;
    checks++; if (uTarget2 !== 8'sd3 || vTarget2 !== -8'sd4)
      $display("FAIL rstm_t2 got %0d %0d want 3 -4", uTarget2, vTarget2); else passed++;
    checks++; if (uTarget1 !== 8'sd0) $display("FAIL rstm_t1 got %0d want 0", uTarget1); else passed++;
  endtask

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    U           = '0;
    V           = '0;
    cal_req     = 1'b0;
    cal_sel     = 1'b0;
    uThresh_in1 = 8'sd8;
    vThresh_in1 = 8'sd8;
    uThresh_in2 = 8'sd8;
    vThresh_in2 = 8'sd8;
    test_reset();
    test_uniform();
    test_rounding();
    test_abort();
    test_lockout();
    test_thresh();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/color_target_calibrator.md
# color_target_calibrator

Configuration controller for the two-color U/V mask stage. It owns the live target and threshold registers that feed the mask comparator. On a calibration request, it averages U/V over a fixed square window in the image center for one frame, then commits the result as the target of the selected color. All register updates to the comparator happen only at frame boundaries, so the mask never changes mid-frame.

## Interface
- YUV_WIDTH, 8, signed width of U, V and targets
- THRESH_WIDTH, 8, signed width of thresholds
- X_WIDTH, 10, pixel column counter width
- Y_WIDTH, 10, pixel row counter width
- WIN_X0, 312, left column of calibration window
- WIN_Y0, 232, top row of calibration window
- WIN_LOG2, 4, log2 of window side; window is 2^WIN_LOG2 × 2^WIN_LOG2 pixels
- U1_DEF / V1_DEF / U2_DEF / V2_DEF, 0 / 0 / 0 / 0, reset targets
- THRESH_DEF, 8, reset value of all four thresholds

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, synchronous, active-low
- frame_start  in  1  one-cycle pulse at start of each frame; never coincident with pix_valid
- pix_valid  in  1  U/V/pix_x/pix_y valid this cycle
- pix_x  in  X_WIDTH  column of current pixel
- pix_y  in  Y_WIDTH  row of current pixel
- U, V  in  YUV_WIDTH signed  chroma of current pixel
- cal_req  in  1  calibration request pulse
- cal_sel  in  1  color to calibrate: 0 = color 1, 1 = color 2; sampled with cal_req
- uThresh_in1, vThresh_in1, uThresh_in2, vThresh_in2  in  THRESH_WIDTH signed  requested thresholds
- uTarget1, vTarget1, uTarget2, vTarget2  out  YUV_WIDTH signed  live targets to mask
- uThresh1, vThresh1, uThresh2, vThresh2  out  THRESH_WIDTH signed  live thresholds to mask
- busy  out  1  calibration in progress
- cal_done  out  1  one-cycle pulse when new target is committed
- cal_err  out  1  one-cycle pulse when calibration aborts

## Operation
- Reset values: targets = *_DEF; thresholds = THRESH_DEF; busy = 0; cal_done = 0; cal_err = 0; state = IDLE; accumulators and count = 0.
- Threshold shadowing: on every frame_start cycle, the four thresh_in values register into the live threshold outputs, independent of FSM state.
- In-window pixel: pix_valid && WIN_X0 ≤ pix_x < WIN_X0+2^WIN_LOG2 && WIN_Y0 ≤ pix_y < WIN_Y0+2^WIN_LOG2.
- NPIX = 2^(2·WIN_LOG2). Count width is 2·WIN_LOG2+1. Sums are signed, YUV_WIDTH+2·WIN_LOG2 bits, with sign-extended accumulation and no overflow possible.
- FSM:
  - IDLE: cal_req → ARM; latch cal_sel and clear sums and count. cal_req in any other state is ignored.
  - ARM: wait for frame_start → ACCUM.
  - ACCUM: for each in-window pixel, add U and V to sums and increment count.
    - The pixel that makes count = NPIX → COMPUTE.
    - frame_start while count < NPIX → IDLE and pulse cal_err; targets stay unchanged.
  - COMPUTE (1 cycle): uAvg = uSum >>> 2·WIN_LOG2 and vAvg = vSum >>> 2·WIN_LOG2. The shift is arithmetic, so rounding is floor toward −∞. Truncate to YUV_WIDTH → COMMIT.
  - COMMIT: wait for frame_start. In that cycle, load uAvg/vAvg into the selected color's targets and pulse cal_done → IDLE. The unselected color's targets are untouched.
- busy = 1 in ARM, ACCUM, COMPUTE, COMMIT.
- reset_n low in any state: return to IDLE with reset values next edge; no partial commit.

## Timing
- All outputs are registered.
- cal_req at cycle t (IDLE) → busy = 1 at t+1.
- frame_start at cycle f in ARM → ACCUM from f+1. Pixels at cycle f are not counted; none exist by contract.
- Final window pixel at cycle n → COMPUTE at n+1, COMMIT at n+2.
- First frame_start at cycle c ≥ n+2 → at c+1, targets updated, cal_done = 1, busy = 0. Threshold update happens at the same edge.
- frame_start at n+1 (COMPUTE) is not a commit point; the next frame_start commits.
- frame_start in ACCUM at cycle a → cal_err = 1 and busy = 0 at a+1.
- Minimum latency from request to commit: two frame_starts after ARM entry.

## Test plan
- Uniform window, cal_sel = 0: all window pixels U = 20, V = −30; out-of-window pixels U = 100 → after second frame_start, uTarget1 = 20, vTarget1 = −30, cal_done pulses once, targets 2 unchanged.
- Rounding, cal_sel = 1, WIN_LOG2 = 4: 128 pixels U = 10 and 128 pixels U = −11 (sum −128) → uTarget2 = −1. V = 127 for all pixels → vTarget2 = 127.
- Abort: frame_start after 100 of 256 window pixels → cal_err pulse, busy = 0, targets equal prior values.
- Busy lockout: cal_req with cal_sel = 1 during ACCUM of a cal_sel = 0 run → only color 1 is updated; exactly one cal_done.
- Reset mid-ACCUM: reset_n low for 1 cycle → all outputs at reset values the next cycle. Then a full calibration succeeds.
- Threshold shadow: change uThresh_in1 from 8 to 15 mid-frame → uThresh1 stays 8 until the cycle after the next frame_start, then reads 15.
